// File: rtl/pipe_fetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fetch_skid
// Description : IF/ID pipeline boundary with valid/ready handshakes on both
//               sides and a two-entry skid buffer. Fetch keeps full throughput
//               under decode backpressure, flush empties the boundary to a
//               bubble, and every output is taken directly from a register.
// Ports       : clk, rst (async, active-high), flush
//               fetch side  : valid_f, ready_f, instr_f, pc_f, pc_plus4_f
//               decode side : valid_d, ready_d, instr_d, pc_d, pc_plus4_d
//               occupancy   : number of entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fetch_skid #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            valid_f,
    output logic            ready_f,
    input  logic [XLEN-1:0] instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus4_f,
    output logic            valid_d,
    input  logic            ready_d,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic [1:0]      occupancy
);

    // Entry layout: {instr, pc, pc_plus4}
    localparam int unsigned      c_ENTRY_W = 3 * XLEN;
    localparam logic [c_ENTRY_W-1:0] c_bubble = {NOP_INSTR, {(2*XLEN){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_ENTRY_W-1:0]   r_main;
    logic [c_ENTRY_W-1:0]   r_skid;
    logic                   r_valid_d;
    logic                   r_ready_f;
    logic [1:0]             r_occupancy;

    logic [c_ENTRY_W-1:0]   w_in;

    assign w_in = {instr_f, pc_f, pc_plus4_f};

    // Handshake flags are kept as their own registers and updated together
    // with the state, so the interface never sees decode logic on its outputs.
    // In ONE and EMPTY ready_f is 1, so push reduces to valid_f there; in FULL
    // ready_f is 0 and valid_f is ignored. In ONE and FULL valid_d is 1, so pop
    // reduces to ready_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_main      <= c_bubble;
            r_skid      <= '0;
            r_valid_d   <= 1'b0;
            r_ready_f   <= 1'b1;
            r_occupancy <= 2'd0;
        end else if (flush) begin
            // Flush wins over any same-cycle push or pop.
            r_state     <= EMPTY;
            r_main      <= c_bubble;
            r_skid      <= '0;
            r_valid_d   <= 1'b0;
            r_ready_f   <= 1'b1;
            r_occupancy <= 2'd0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (valid_f) begin
                        r_main      <= w_in;
                        r_state     <= ONE;
                        r_valid_d   <= 1'b1;
                        r_occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (valid_f && ready_d) begin
                        r_main <= w_in;
                    end else if (valid_f) begin
                        // Decode stalled: park the new entry behind M.
                        r_skid      <= w_in;
                        r_state     <= FULL;
                        r_ready_f   <= 1'b0;
                        r_occupancy <= 2'd2;
                    end else if (ready_d) begin
                        // Last entry consumed: present a bubble.
                        r_main      <= c_bubble;
                        r_state     <= EMPTY;
                        r_valid_d   <= 1'b0;
                        r_occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (ready_d) begin
                        r_main      <= r_skid;
                        r_skid      <= '0;
                        r_state     <= ONE;
                        r_ready_f   <= 1'b1;
                        r_occupancy <= 2'd1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main      <= c_bubble;
                    r_skid      <= '0;
                    r_valid_d   <= 1'b0;
                    r_ready_f   <= 1'b1;
                    r_occupancy <= 2'd0;
                end
            endcase
        end
    end

    assign ready_f    = r_ready_f;
    assign valid_d    = r_valid_d;
    assign occupancy  = r_occupancy;
    assign instr_d    = r_main[c_ENTRY_W-1 -: XLEN];
    assign pc_d       = r_main[2*XLEN-1 -: XLEN];
    assign pc_plus4_d = r_main[XLEN-1:0];

endmodule
`default_nettype wire
